multiplicador_seq: RTL and testbench

- Sequential shift-and-add unsigned multiplier.
- Inverse companion to the restoring divider's subtract-and-shift datapath. It adds the multiplicand into a partial product and shifts right, one multiplier bit per clock.
- Sits beside the divider in the arithmetic unit and feeds its product to the same result bus.
- Uses a start/busy/done handshake.

---
 rtl/multiplicador_seq_pkg.sv | 18 +
 rtl/multiplicador_seq_if.sv | 17 +
 rtl/multiplicador_seq_somador_nbits.sv | 25 ++
 rtl/multiplicador_seq.sv | 108 ++++++++++
 tb/tb_multiplicador_seq.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/multiplicador_seq_pkg.sv
// Shared arithmetic-unit definitions: FSM state encoding and the default
// operand width, common to the sequential multiplier and divider control.
package multiplicador_seq_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Iteration counter width: enough to hold WIDTH-1 plus one spare bit.
   function automatic int count_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/multiplicador_seq_if.sv
// Start/busy/done handshake bundle between the requester and the multiplier.
interface multiplicador_seq_if #(
   parameter int WIDTH = multiplicador_seq_pkg::DEFAULT_WIDTH
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [2*WIDTH-1:0]   p;
   logic                 busy;
   logic                 done;

   modport master (output start, output a, output b,
                   input  p, input busy, input done);

   modport slave  (input  start, input a, input b,
                   output p, output busy, output done);
endinterface

// File: rtl/multiplicador_seq_somador_nbits.sv
// WIDTH-bit ripple-carry adder made of full-adder cells; structural twin of
// the divider's subtractor chain.
module somador_nbits #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic [WIDTH:0] c;

   assign c[0] = cin;

   // One full-adder cell per bit, carry rippling upward.
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
   end

   assign cout = c[WIDTH];

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential shift-and-add unsigned multiplier: one multiplier bit per clock,
// fixed WIDTH-cycle latency, start/busy/done handshake.
module multiplicador_seq
   import multiplicador_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multiplicador_seq_if.slave   bus
);

   localparam int CW = count_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t               state;
   logic [WIDTH-1:0]     acc;
   logic [WIDTH-1:0]     q;
   logic [WIDTH-1:0]     m;
   logic [CW-1:0]        count;
   logic [2*WIDTH-1:0]   p_r;
   logic                 busy_r;
   logic                 done_r;

   logic [WIDTH-1:0]     addend;
   logic [WIDTH-1:0]     sum;
   logic                 carry;
   logic [WIDTH-1:0]     acc_nxt;
   logic [WIDTH-1:0]     q_nxt;

   // Add the multiplicand only when the current multiplier LSB is set.
   assign addend = q[0] ? m : '0;

   somador_nbits #(.WIDTH(WIDTH)) u_somador (
      .x    (acc),
      .y    (addend),
      .cin  (1'b0),
      .s    (sum),
      .cout (carry)
   );

   // Shift {carry, sum, q} right by one: the carry is never lost, so the
   // full 2*WIDTH-bit product always fits.
   assign acc_nxt = {carry, sum[WIDTH-1:1]};
   assign q_nxt   = {sum[0], q[WIDTH-1:1]};

   assign bus.p    = p_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;

   // Control FSM plus shift registers, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         acc    <= '0;
         q      <= '0;
         m      <= '0;
         count  <= '0;
         p_r    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  m      <= bus.a;
                  q      <= bus.b;
                  acc    <= '0;
                  count  <= '0;
                  busy_r <= 1'b1;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               acc   <= acc_nxt;
               q     <= q_nxt;
               count <= count + 1'b1;
               if (count == LAST) begin
                  p_r    <= {acc_nxt, q_nxt};
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  // Back-to-back request loads exactly as from idle.
                  m      <= bus.a;
                  q      <= bus.b;
                  acc    <= '0;
                  count  <= '0;
                  busy_r <= 1'b1;
                  state  <= S_RUN;
               end else begin
                  state  <= S_IDLE;
               end
            end
            default: begin
               state  <= S_IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiplicador_seq.sv
// Bench for multiplicador_seq: directed table, handshake corner sequences,
// random and partial exhaustive sweeps against an a*b reference.
module tb_multiplicador_seq;

   localparam int W = 8;

   logic clk;
   logic rst_n;

   multiplicador_seq_if #(.WIDTH(W)) bus ();

   multiplicador_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] exp;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Issue one request (called at posedge+#1 while idle or in a done cycle)
   // and follow it to its done pulse. Optionally pulses a second start with
   // operands ga/gb 'glitch' cycles into the run.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input int glitch, input logic [W-1:0] ga, input logic [W-1:0] gb,
                         output logic [2*W-1:0] prod, output int lat,
                         output int busy_cnt, output int overlap, output bit got);
      bus.a = ta;
      bus.b = tb_v;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 0; busy_cnt = 0; overlap = 0; got = 0; prod = '0;
      for (int i = 0; i < 40; i++) begin
         if (bus.busy && bus.done) overlap++;
         if (bus.done) begin
            prod = bus.p;
            got = 1;
            break;
         end
         if (bus.busy) busy_cnt++;
         if (lat == glitch) begin
            bus.start = 1'b1;
            bus.a = ga;
            bus.b = gb;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      bus.start = 1'b0;
   endtask

   task automatic op_and_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                               input logic [2*W-1:0] exp, input bit full);
      logic [2*W-1:0] prod;
      int lat, bc, ov;
      bit got;
      run_op(ta, tb_v, -1, '0, '0, prod, lat, bc, ov, got);
      if (!got) begin
         check({tag, "_timeout"}, 32'(got), 32'd1);
      end else begin
         check({tag, "_p"}, 32'(prod), 32'(exp));
         check({tag, "_lat"}, 32'(lat), 32'(W));
         if (full) begin
            check({tag, "_busy_cycles"}, 32'(bc), 32'(W));
            check({tag, "_overlap"}, 32'(ov), 32'd0);
         end
      end
   endtask

   initial begin
      logic [2*W-1:0] prod;
      int lat, bc, ov;
      bit got;
      logic [W-1:0] ra, rb;
      int dn_seen;

      n_checks = 0;
      n_fail = 0;

      vecs[0] = '{a: 8'd255, b: 8'd255, exp: 16'hFE01};
      vecs[1] = '{a: 8'd0,   b: 8'd200, exp: 16'h0000};
      vecs[2] = '{a: 8'd200, b: 8'd0,   exp: 16'h0000};
      vecs[3] = '{a: 8'd1,   b: 8'd1,   exp: 16'h0001};
      vecs[4] = '{a: 8'd255, b: 8'd1,   exp: 16'h00FF};
      vecs[5] = '{a: 8'd128, b: 8'd2,   exp: 16'h0100};

      // Reset state
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      @(posedge clk); @(posedge clk); #1;
      check("reset_p", 32'(bus.p), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 13 x 11, then one idle cycle with p held
      op_and_check("t1", 8'd13, 8'd11, 16'h008F, 1'b1);
      @(posedge clk); #1;
      check("t1_held_p", 32'(bus.p), 32'h008F);
      check("t1_idle_done", 32'(bus.done), 32'd0);
      check("t1_idle_busy", 32'(bus.busy), 32'd0);

      // Directed table
      for (int i = 0; i < 6; i++) begin
         op_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
         @(posedge clk); #1;
      end

      // Start during RUN is ignored
      run_op(8'd3, 8'd5, 3, 8'd9, 8'd9, prod, lat, bc, ov, got);
      check("t3_got", 32'(got), 32'd1);
      check("t3_p", 32'(prod), 32'd15);
      check("t3_lat", 32'(lat), 32'(W));
      check("t3_busy_cycles", 32'(bc), 32'(W));
      @(posedge clk); #1;
      check("t3_no_restart_busy", 32'(bus.busy), 32'd0);
      check("t3_no_restart_done", 32'(bus.done), 32'd0);
      @(posedge clk); #1;

      // Back-to-back: second start held in the done cycle
      op_and_check("t4a", 8'd7, 8'd6, 16'd42, 1'b1);
      op_and_check("t4b", 8'd10, 8'd12, 16'd120, 1'b1);
      @(posedge clk); #1;

      // Reset mid-operation
      bus.a = 8'd100;
      bus.b = 8'd100;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      dn_seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus.done) dn_seen++;
      end
      check("t5_busy_before", 32'(bus.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_p", 32'(bus.p), 32'd0);
      check("t5_async_busy", 32'(bus.busy), 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus.done) dn_seen++;
      end
      check("t5_no_done", 32'(dn_seen), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      op_and_check("t5_after", 8'd2, 8'd3, 16'd6, 1'b1);
      @(posedge clk); #1;

      // Random sweep, chained back-to-back
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         op_and_check("rand", ra, rb, 16'(32'(ra) * 32'(rb)), 1'b0);
      end
      @(posedge clk); #1;

      // Exhaustive multiplier sweep for small multiplicands and the maximum one
      for (int ia = 0; ia < 9; ia++) begin
         ra = (ia == 8) ? 8'd255 : W'(ia);
         for (int ib = 0; ib < 256; ib++) begin
            rb = W'(ib);
            op_and_check("exh", ra, rb, 16'(32'(ra) * 32'(rb)), 1'b0);
         end
      end
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

endmodule
